// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, defaults and helpers for req_priority_arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ  = 8;
    localparam int DEF_MAX_HOLD = 16;
    localparam int MAX_REQ      = 16;
    localparam int MAX_ID_W     = 4;

    // Widest one-hot vector; callers truncate to their own NUM_REQ.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_ID_W-1:0] id);
        onehot = MAX_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/arb_req_picker.sv
// rtl/arb_req_picker.sv - combinational descending priority search with wrap-around.
module arb_req_picker #(
    parameter int NUM_REQ = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic [ID_W-1:0]    winner,
    output logic               found
);

    logic [ID_W-1:0] idx;

    // Walk from the lowest priority slot up so the last hit is the closest to start.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = start - ID_W'(k);
            if (req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_priority_arbiter.sv
// rtl/req_priority_arbiter.sv - registered single-owner arbiter with hold timeout and turnaround gap; ARB_ROUND_ROBIN_EN selects rotating priority.
module req_priority_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout,
    output logic               busy
);

    arb_state_t        state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [ID_W-1:0]    gnt_id_nxt;
    logic               gnt_valid_nxt;
    logic               timeout_nxt;
    logic               busy_nxt;
    logic [7:0]         hold_cnt, hold_cnt_nxt;
    logic [ID_W-1:0]    last_id, last_id_nxt;
    logic               timed_out, timed_out_nxt;

    logic [NUM_REQ-1:0] last_mask;
    logic [NUM_REQ-1:0] req_other;
    logic [NUM_REQ-1:0] req_eff;
    logic [ID_W-1:0]    start;
    logic [ID_W-1:0]    winner;
    logic               found;

`ifdef ARB_ROUND_ROBIN_EN
    assign start = last_id - ID_W'(1);
`else
    assign start = ID_W'(NUM_REQ - 1);
`endif

    // A timed-out owner steps aside for one round, unless nobody else wants the resource.
    assign last_mask = NUM_REQ'(onehot(MAX_ID_W'(last_id)));
    assign req_other = req & ~last_mask;
    assign req_eff   = (state == GAP && timed_out && |req_other) ? req_other : req;

    arb_req_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req    (req_eff),
        .start  (start),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;
        hold_cnt_nxt  = hold_cnt;
        last_id_nxt   = last_id;
        timed_out_nxt = timed_out;

        case (state)
            IDLE, GAP: begin
                if (found) begin
                    state_nxt     = GRANT;
                    gnt_nxt       = NUM_REQ'(onehot(MAX_ID_W'(winner)));
                    gnt_id_nxt    = winner;
                    gnt_valid_nxt = 1'b1;
                    hold_cnt_nxt  = 8'd0;
                    last_id_nxt   = winner;
                    timed_out_nxt = 1'b0;
                end else begin
                    state_nxt     = IDLE;
                    timed_out_nxt = 1'b0;
                end
            end
            GRANT: begin
                hold_cnt_nxt = hold_cnt + 8'd1;
                if (!req[gnt_id] || hold_cnt == 8'(MAX_HOLD - 1)) begin
                    state_nxt     = GAP;
                    gnt_nxt       = '0;
                    gnt_id_nxt    = '0;
                    gnt_valid_nxt = 1'b0;
                    timeout_nxt   = req[gnt_id];
                    timed_out_nxt = req[gnt_id];
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            hold_cnt  <= 8'd0;
            last_id   <= '0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
            busy      <= busy_nxt;
            hold_cnt  <= hold_cnt_nxt;
            last_id   <= last_id_nxt;
            timed_out <= timed_out_nxt;
        end
    end

endmodule

// File: tb/tb_req_priority_arbiter.sv
// tb/tb_req_priority_arbiter.sv - randomized and directed self-checking bench for req_priority_arbiter.
module tb_req_priority_arbiter;

    localparam int N    = 8;
    localparam int IW   = 3;
    localparam int HOLD = 16;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          gnt_valid;
    logic          timeout;
    logic          busy;

    int checks = 0;
    int errors = 0;

    req_priority_arbiter #(
        .NUM_REQ  (N),
        .ID_W     (IW),
        .MAX_HOLD (HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: who owns the resource, for how many cycles, and whether we sit in a gap.
    int  m_owner = -1;
    int  m_held  = 0;
    bit  m_gap   = 0;
    bit  m_to    = 0;
    int  m_last  = 0;
    bit  e_to    = 0;

    function automatic int pick(input logic [N-1:0] cand, input int last);
        int start;
`ifdef ARB_ROUND_ROBIN_EN
        start = (last + N - 1) % N;
`else
        start = N - 1;
`endif
        for (int k = 0; k < N; k++) begin
            if (cand[(start - k + N) % N]) return (start - k + N) % N;
        end
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1; m_held = 0; m_gap = 0; m_to = 0; m_last = 0; e_to = 0;
            end else begin
                e_to = 0;
                if (m_owner >= 0) begin
                    m_held++;
                    if (!req[m_owner] || m_held == HOLD) begin
                        e_to    = req[m_owner];
                        m_to    = req[m_owner];
                        m_owner = -1;
                        m_gap   = 1;
                    end
                end else begin
                    logic [N-1:0] cand;
                    logic [N-1:0] others;
                    int w;
                    others = req;
                    others[m_last] = 1'b0;
                    cand = (m_gap && m_to && others != 0) ? others : req;
                    w = pick(cand, m_last);
                    if (w >= 0) begin
                        m_owner = w; m_held = 0; m_last = w;
                    end
                    m_gap = 0;
                    m_to  = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0]  x_gnt;
        logic [IW-1:0] x_id;
        bit            x_busy;
        x_gnt  = (m_owner >= 0) ? N'(1) << m_owner : '0;
        x_id   = (m_owner >= 0) ? IW'(m_owner) : '0;
        x_busy = (m_owner >= 0) || m_gap;
        checks++;
        if (gnt !== x_gnt || gnt_id !== x_id || gnt_valid !== (m_owner >= 0)
            || timeout !== e_to || busy !== x_busy) begin
            errors++;
            $display("FAIL model_cmp t=%0t gnt=%h exp %h id=%0d exp %0d valid=%b exp %b timeout=%b exp %b busy=%b exp %b",
                     $time, gnt, x_gnt, gnt_id, x_id, gnt_valid, (m_owner >= 0), timeout, e_to, busy, x_busy);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        #2;
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_valid", int'(gnt_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_id_to", int'({gnt_id, timeout}), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        req = 8'h01;
        step();
        chk("first_gnt", int'(gnt), 8'h01);
        chk("first_valid_id", int'({gnt_valid, gnt_id}), 8'h08);
        req = 8'h00;
        step();
        chk("rel_gap_gnt", int'(gnt), 0);
        chk("rel_gap_busy_to", int'({busy, timeout}), 2);
        step();
        chk("back_idle_busy", int'(busy), 0);

        req = 8'h84;
        step();
        chk("prio_hi", int'(gnt), 8'h80);
        req = 8'h04;
        step();
        chk("gap_between_owners", int'(gnt), 0);
        step();
        chk("next_owner_gnt", int'(gnt), 8'h04);
        chk("next_owner_id", int'(gnt_id), 2);
        req = 8'h00;
        step();
        step();

        req = 8'h08;
        step();
        chk("hold_start", int'(gnt), 8'h08);
        repeat (HOLD - 1) step();
        chk("hold_last_cycle", int'({gnt, timeout}), 9'h010);
        step();
        chk("timeout_pulse", int'({gnt, timeout}), 9'h001);
        step();
        chk("sole_regrant", int'({gnt, timeout}), 9'h010);
        req = 8'h00;
        step();
        step();

        req = 8'h42;
        step();
        chk("alt_first_6", int'(gnt), 8'h40);
        repeat (HOLD) step();
        chk("alt_6_timeout", int'(timeout), 1);
        step();
        chk("alt_then_1", int'(gnt), 8'h02);
        repeat (HOLD) step();
        chk("alt_1_timeout", int'(timeout), 1);
        step();
        chk("alt_back_6", int'(gnt), 8'h40);
        req = 8'h00;
        step();
        step();

        req = 8'h10;
        step();
        chk("pre_reset_gnt", int'(gnt), 8'h10);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_gnt", int'(gnt), 0);
        chk("async_reset_valid_busy", int'({gnt_valid, busy}), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        chk("post_reset_idle", int'(gnt), 0);
        step();
        chk("post_reset_regrant", int'(gnt), 8'h10);

        for (int c = 0; c < 4000; c++) begin
            step();
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 40) == 0) req = '0;
            if ($urandom_range(0, 600) == 0) begin
                #1 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
